alu_trace_uart: RTL and testbench

- Downstream debug/trace stage for the RISC-V core. It consumes the core's top-level ALU_out bus.
- On every change of ALU_out it captures the new value into a small FIFO.
- It serialises each captured word over a UART TX line (8N1, four bytes per word, least-significant byte first).
- Purpose: lets a board or testbench observe program progress with one pin and no access to core internals.

---
 rtl/alu_trace_uart_pkg.sv | 15 +
 rtl/trace_sync_fifo.sv | 50 +++++
 rtl/alu_trace_uart.sv | 166 ++++++++++++++++
 tb/tb_alu_trace_uart.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/alu_trace_uart_pkg.sv
// Shared defaults and TX state encoding for the ALU trace UART.
package alu_trace_uart_pkg;
  localparam int TRACE_WORD_WIDTH     = 32;
  localparam int TRACE_BYTES_PER_WORD = TRACE_WORD_WIDTH / 8;
  localparam int TRACE_CLKS_PER_BIT   = 16;
  localparam int TRACE_FIFO_DEPTH     = 8;
  localparam int TRACE_DROP_CNT_W     = 8;

  typedef enum logic [1:0] {
    trace_idle,
    trace_start,
    trace_data,
    trace_stop
  } trace_state_e;
endpackage

// File: rtl/trace_sync_fifo.sv
// Single-clock FIFO; a push is refused whenever the pre-edge count is full.
module trace_sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_din,
  output logic [W-1:0]  o_dout,
  output logic [AW:0]   o_count,
  output logic          o_full,
  output logic          o_empty
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          w_do_push, w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_dout    = r_mem[r_rptr];
  assign o_count   = r_count;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/alu_trace_uart.sv
// Captures each change of the core's ALU result and streams it out as 8N1 UART bytes, LSB byte first.
module alu_trace_uart
  import alu_trace_uart_pkg::*;
#(
  parameter int WORD_WIDTH   = TRACE_WORD_WIDTH,
  parameter int CLKS_PER_BIT = TRACE_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = TRACE_FIFO_DEPTH,
  parameter int DROP_CNT_W   = TRACE_DROP_CNT_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WORD_WIDTH-1:0]       ALU_out,
  input  logic                        en,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic [DROP_CNT_W-1:0]       drop_count
);
  localparam int BYTES  = WORD_WIDTH / 8;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BYTE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BYTES - 1);

  logic                  r_first_seen;
  logic [WORD_WIDTH-1:0] r_last_seen;
  logic                  r_overflow;
  logic [DROP_CNT_W-1:0] r_drop_cnt;
  trace_state_e          r_state;
  logic [BAUD_W-1:0]     r_baud;
  logic [2:0]            r_bit;
  logic [BYTE_W-1:0]     r_byte;
  logic [WORD_WIDTH-1:0] r_shift;
  logic                  r_tx;

  logic                  w_valid, w_push, w_pop, w_full, w_empty, w_baud_done, w_tx_nxt;
  logic [WORD_WIDTH-1:0] w_head, w_shift_nxt;
  trace_state_e          w_state_nxt;
  logic [BAUD_W-1:0]     w_baud_nxt;
  logic [2:0]            w_bit_nxt;
  logic [BYTE_W-1:0]     w_byte_nxt;
  logic [7:0]            w_cur_byte;

  assign w_valid = en && (!r_first_seen || (ALU_out != r_last_seen));
  assign w_push  = w_valid;

  trace_sync_fifo #(.W(WORD_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (ALU_out),
    .o_dout  (w_head),
    .o_count (fifo_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_first_seen <= 1'b0;
      r_last_seen  <= '0;
      r_overflow   <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      if (en) begin
        r_first_seen <= 1'b1;
        r_last_seen  <= ALU_out;
      end
      if (w_valid && w_full) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != {DROP_CNT_W{1'b1}}) r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_byte_nxt  = r_byte;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    w_baud_done = (r_baud == BAUD_LAST);
    case (r_state)
      trace_idle: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_byte_nxt  = '0;
          w_baud_nxt  = '0;
          w_state_nxt = trace_start;
        end
      end
      trace_start: begin
        if (w_baud_done) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = trace_data;
        end else begin
          w_baud_nxt = r_baud + BAUD_W'(1);
        end
      end
      trace_data: begin
        if (w_baud_done) begin
          w_baud_nxt = '0;
          if (r_bit == 3'd7) w_state_nxt = trace_stop;
          else               w_bit_nxt   = r_bit + 3'd1;
        end else begin
          w_baud_nxt = r_baud + BAUD_W'(1);
        end
      end
      trace_stop: begin
        if (w_baud_done) begin
          w_baud_nxt = '0;
          if (r_byte != BYTE_LAST) begin
            w_byte_nxt  = r_byte + BYTE_W'(1);
            w_state_nxt = trace_start;
          end else if (!w_empty) begin
            // chain straight into the next word so there is no idle gap
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_byte_nxt  = '0;
            w_state_nxt = trace_start;
          end else begin
            w_state_nxt = trace_idle;
          end
        end else begin
          w_baud_nxt = r_baud + BAUD_W'(1);
        end
      end
      default: w_state_nxt = trace_idle;
    endcase

    w_cur_byte = w_shift_nxt[w_byte_nxt*8 +: 8];
    case (w_state_nxt)
      trace_start: w_tx_nxt = 1'b0;
      trace_data:  w_tx_nxt = w_cur_byte[w_bit_nxt];
      default:     w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= trace_idle;
      r_baud  <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_byte  <= w_byte_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  assign tx         = r_tx;
  assign busy       = (r_state != trace_idle);
  assign overflow   = r_overflow;
  assign drop_count = r_drop_cnt;
endmodule

// File: tb/tb_alu_trace_uart.sv
// Directed bench: drives ALU_out patterns and decodes the UART line with a background receiver.
module tb_alu_trace_uart;
  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic [31:0] alu = '0;
  logic        tx, busy, overflow;
  logic [3:0]  fifo_count;
  logic [7:0]  drop_count;

  int passes = 0;
  int total  = 0;
  logic [7:0] rxq[$];

  alu_trace_uart dut (
    .clk        (clk),
    .rst        (rst),
    .ALU_out    (alu),
    .en         (en),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] rx_word(input int base);
    if (rxq.size() < base + 4) return 32'hxxxxxxxx;
    return {rxq[base+3], rxq[base+2], rxq[base+1], rxq[base]};
  endfunction

  // mid-bit sampling UART receiver; bytes land in rxq
  initial begin : rx
    logic [7:0] b;
    b = '0;
    forever begin
      @(negedge tx);
      repeat (CPB/2) @(posedge clk);
      #1;
      if (tx === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(posedge clk);
          #1;
          b[i] = tx;
        end
        repeat (CPB) @(posedge clk);
        #1;
        rxq.push_back(b);
      end
    end
  end

  initial begin : main
    int n;
    n = 0;
    repeat (3) tick();
    chk("reset_tx",    32'(tx), 32'd1);
    chk("reset_busy",  32'(busy), 32'd0);
    chk("reset_count", 32'(fifo_count), 32'd0);
    chk("reset_ovf",   32'(overflow), 32'd0);
    chk("reset_drop",  32'(drop_count), 32'd0);
    rst = 1'b1;
    repeat (2) tick();

    // single word, held value
    alu = 32'h12345678; en = 1'b1;
    tick();
    chk("t1_capture_count", 32'(fifo_count), 32'd1);
    chk("t1_tx_at_capture", 32'(tx), 32'd1);
    tick();
    chk("t1_start_bit", 32'(tx), 32'd0);
    chk("t1_busy",      32'(busy), 32'd1);
    chk("t1_popped",    32'(fifo_count), 32'd0);
    n = 0;
    while (busy === 1'b1 && n < 2000) begin n++; tick(); end
    chk("t1_busy_cycles", 32'(n), 32'd640);
    repeat (1300) tick();
    chk("t1_rx_bytes", 32'(rxq.size()), 32'd4);
    chk("t1_word",     rx_word(0), 32'h12345678);
    chk("t1_count_end", 32'(fifo_count), 32'd0);

    // repeat is ignored, step is captured
    rxq.delete();
    repeat (20) tick();
    chk("t2_repeat_count", 32'(fifo_count), 32'd0);
    chk("t2_repeat_busy",  32'(busy), 32'd0);
    alu = 32'hDEADBEEF;
    tick(); tick();
    n = 0;
    while (busy === 1'b1 && n < 2000) begin n++; tick(); end
    repeat (20) tick();
    chk("t2_rx_bytes", 32'(rxq.size()), 32'd4);
    chk("t2_word",     rx_word(0), 32'hDEADBEEF);
    repeat (200) tick();
    chk("t2_no_extra", 32'(rxq.size()), 32'd4);

    // burst of 20 distinct values into an 8-deep FIFO
    rxq.delete();
    for (int i = 0; i < 20; i++) begin alu = 32'(i); tick(); end
    chk("t3_drop",  32'(drop_count), 32'd11);
    chk("t3_ovf",   32'(overflow), 32'd1);
    chk("t3_count", 32'(fifo_count), 32'd8);
    n = 0;
    while (busy === 1'b1 && n < 7000) begin n++; tick(); end
    repeat (20) tick();
    chk("t3_rx_bytes", 32'(rxq.size()), 32'd36);
    for (int i = 0; i < 9; i++) chk($sformatf("t3_word%0d", i), rx_word(4*i), 32'(i));
    chk("t3_ovf_sticky", 32'(overflow), 32'd1);
    chk("t3_count_end",  32'(fifo_count), 32'd0);

    // saturation of the drop counter
    for (int i = 0; i < 308; i++) begin alu = 32'h1000 + 32'(i); tick(); end
    chk("t4_drop_sat", 32'(drop_count), 32'd255);
    for (int i = 0; i < 5; i++) begin alu = 32'h2000 + 32'(i); tick(); end
    chk("t4_no_wrap", 32'(drop_count), 32'd255);
    chk("t4_ovf",     32'(overflow), 32'd1);
    n = 0;
    while (busy === 1'b1 && n < 7000) begin n++; tick(); end
    chk("t4_drained", 32'(fifo_count), 32'd0);

    // reset in DATA of byte 2 (byte 0xA5, bit 3 = 0)
    alu = 32'hA5A50F0F;
    tick(); tick();
    chk("t5_busy", 32'(busy), 32'd1);
    alu = 32'h0BADF00D;
    tick();
    chk("t5_queued", 32'(fifo_count), 32'd1);
    repeat (398) tick();
    chk("t5_pre_reset_tx", 32'(tx), 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("t5_rst_tx",    32'(tx), 32'd1);
    chk("t5_rst_busy",  32'(busy), 32'd0);
    chk("t5_rst_count", 32'(fifo_count), 32'd0);
    chk("t5_rst_drop",  32'(drop_count), 32'd0);
    en = 1'b0;
    tick();
    rst = 1'b1;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      alu = 32'h5000 + 32'(3*i);
      tick();
      if (tx !== 1'b1) n++;
    end
    chk("t5_tx_high_en0", 32'(n), 32'd0);
    chk("t5_count_en0",   32'(fifo_count), 32'd0);
    chk("t5_busy_en0",    32'(busy), 32'd0);
    repeat (150) tick();
    rxq.delete();

    // first capture after enable
    alu = 32'h7E570001;
    tick();
    en = 1'b1;
    tick();
    chk("t6_capture", 32'(fifo_count), 32'd1);
    tick();
    chk("t6_start_bit", 32'(tx), 32'd0);
    n = 0;
    while (busy === 1'b1 && n < 2000) begin n++; tick(); end
    repeat (100) tick();
    chk("t6_rx_bytes", 32'(rxq.size()), 32'd4);
    chk("t6_word",     rx_word(0), 32'h7E570001);
    chk("t6_idle",     32'(busy), 32'd0);
    chk("t6_count",    32'(fifo_count), 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
